decode_writeback: RTL and testbench

- Register-file stage of the SEQ Y86-64 core, directly downstream of fetch.
- Consumes icode/rA/rB from fetch, and produces valA/valB combinationally for execute.
- Commits valE/valM from execute/memory into the 15-entry register file at the clock edge.
- Holds the architectural status state machine (AOK/HLT/ADR/INS), which freezes writeback once the processor stops.

---
 rtl/decode_writeback.sv | 135 +++++++++++++
 tb/tb_decode_writeback.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/decode_writeback.sv
// SEQ Y86-64 decode/writeback stage: register file reads, commit of valE/valM,
// and the architectural status state machine.
module decode_writeback #(
  parameter logic [63:0] STACK_INIT = 64'd512,
  parameter logic [63:0] REG_RESET  = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic        instruct_error,
  input  logic        mem_error,
  input  logic        cnd,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  output logic [63:0] valA,
  output logic [63:0] valB,
  output logic [1:0]  stat,
  input  logic [3:0]  dbg_addr,
  output logic [63:0] dbg_data
);

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

  typedef enum logic [1:0] {
    S_AOK = 2'd0,
    S_HLT = 2'd1,
    S_ADR = 2'd2,
    S_INS = 2'd3
  } stat_e;

  stat_e       stat_q, stat_d;
  logic [63:0] regs_q [0:14];
  logic [63:0] regs_d [0:14];

  logic [3:0] src_a, src_b, dst_e, dst_m;
  logic       commit;
  logic [3:0] unused_ifun;

  assign unused_ifun = ifun;

  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (icode)
      4'h2: begin
        src_a = rA;
        dst_e = cnd ? rB : RNONE;
      end
      4'h3: dst_e = rB;
      4'h4: begin
        src_a = rA;
        src_b = rB;
      end
      4'h5: begin
        src_b = rB;
        dst_m = rA;
      end
      4'h6: begin
        src_a = rA;
        src_b = rB;
        dst_e = rB;
      end
      4'h8: begin
        src_b = RSP;
        dst_e = RSP;
      end
      4'h9: begin
        src_a = RSP;
        src_b = RSP;
        dst_e = RSP;
      end
      4'hA: begin
        src_a = rA;
        src_b = RSP;
        dst_e = RSP;
      end
      4'hB: begin
        src_a = RSP;
        src_b = RSP;
        dst_e = RSP;
        dst_m = rA;
      end
      default: ;
    endcase
  end

  always_comb begin
    valA = '0;
    valB = '0;
    dbg_data = '0;
    if (src_a != RNONE) valA = regs_q[src_a];
    if (src_b != RNONE) valB = regs_q[src_b];
    if (dbg_addr != RNONE) dbg_data = regs_q[dbg_addr];
  end

  assign commit = valid && (stat_q == S_AOK)
                  && !instruct_error && !mem_error;

  // dstM is applied after dstE so popq %rsp keeps the loaded value
  always_comb begin
    for (int i = 0; i < 15; i++) regs_d[i] = regs_q[i];
    if (commit && dst_e != RNONE) regs_d[dst_e] = valE;
    if (commit && dst_m != RNONE) regs_d[dst_m] = valM;
  end

  always_comb begin
    stat_d = stat_q;
    if (valid && stat_q == S_AOK) begin
      if (instruct_error)     stat_d = S_INS;
      else if (mem_error)     stat_d = S_ADR;
      else if (icode == 4'h0) stat_d = S_HLT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_q <= S_AOK;
      for (int i = 0; i < 15; i++)
        regs_q[i] <= (i == 4) ? STACK_INIT : REG_RESET;
    end else begin
      stat_q <= stat_d;
      for (int i = 0; i < 15; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign stat = stat_q;

endmodule

// File: tb/tb_decode_writeback.sv
// Bench for decode_writeback: directed plan steps then randomized traffic,
// all checked against a register-file/status model.
module tb_decode_writeback;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [3:0]  icode, ifun, rA, rB;
  logic        instruct_error, mem_error, cnd;
  logic [63:0] valE, valM;
  logic [63:0] valA, valB;
  logic [1:0]  stat;
  logic [3:0]  dbg_addr;
  logic [63:0] dbg_data;

  int checks = 0;
  int failures = 0;

  logic [63:0] m_reg [0:14];
  logic [1:0]  m_stat;

  decode_writeback #(.STACK_INIT(64'd512), .REG_RESET(64'd0)) dut (
    .clk(clk), .rst(rst), .valid(valid),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
    .instruct_error(instruct_error), .mem_error(mem_error),
    .cnd(cnd), .valE(valE), .valM(valM),
    .valA(valA), .valB(valB), .stat(stat),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] m_rd(input logic [3:0] id);
    return (id == 4'hF) ? 64'd0 : m_reg[id];
  endfunction

  function automatic logic [3:0] m_srcA(input logic [3:0] ic,
                                        input logic [3:0] ra);
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
    if (ic inside {4'h9, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_srcB(input logic [3:0] ic,
                                        input logic [3:0] rb);
    if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dstE(input logic [3:0] ic,
                                        input logic [3:0] rb,
                                        input logic c);
    if (ic inside {4'h3, 4'h6}) return rb;
    if (ic == 4'h2) return c ? rb : 4'hF;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dstM(input logic [3:0] ic,
                                        input logic [3:0] ra);
    if (ic inside {4'h5, 4'hB}) return ra;
    return 4'hF;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 15; i++) m_reg[i] = (i == 4) ? 64'd512 : 64'd0;
    m_stat = 2'd0;
  endtask

  // Drive one instruction cycle at negedge, check reads, then model the edge.
  task automatic step(input logic v, input logic [3:0] ic,
                      input logic [3:0] ra, input logic [3:0] rb,
                      input logic ie, input logic me, input logic c,
                      input logic [63:0] e, input logic [63:0] m,
                      input logic r);
    logic [3:0] de, dm;
    valid = v; icode = ic; ifun = 4'($urandom_range(0, 15));
    rA = ra; rB = rb; instruct_error = ie; mem_error = me;
    cnd = c; valE = e; valM = m; rst = r;
    dbg_addr = 4'($urandom_range(0, 15));
    #1;
    chk("valA", valA, m_rd(m_srcA(ic, ra)));
    chk("valB", valB, m_rd(m_srcB(ic, rb)));
    chk("stat", {62'd0, stat}, {62'd0, m_stat});
    chk("dbg", dbg_data, m_rd(dbg_addr));
    @(posedge clk);
    if (r) begin
      m_reset();
    end else if (v && m_stat == 2'd0) begin
      if (!ie && !me) begin
        de = m_dstE(ic, rb, c);
        dm = m_dstM(ic, ra);
        if (de != 4'hF) m_reg[de] = e;
        if (dm != 4'hF) m_reg[dm] = m;
      end
      if (ie) m_stat = 2'd3;
      else if (me) m_stat = 2'd2;
      else if (ic == 4'h0) m_stat = 2'd1;
    end
    @(negedge clk);
  endtask

  task automatic peek(input string tag, input logic [3:0] a,
                      input logic [63:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  task automatic idle();
    step(1'b0, 4'h1, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
  endtask

  initial begin
    logic [3:0] ic;
    logic r;
    valid = 0; icode = 0; ifun = 0; rA = 4'hF; rB = 4'hF;
    instruct_error = 0; mem_error = 0; cnd = 0;
    valE = 0; valM = 0; dbg_addr = 0; rst = 1;
    @(posedge clk);
    m_reset();
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < 16; i++)
      peek("rst_reg", 4'(i), (i == 4) ? 64'd512 : 64'd0);
    chk("rst_stat", {62'd0, stat}, 64'd0);

    step(1, 4'h3, 4'hF, 4'h2, 0, 0, 0, 64'h1234, 64'd0, 0);
    step(1, 4'h6, 4'h2, 4'h2, 0, 0, 0, 64'h55, 64'd0, 0);
    chk("opq_plan_reg2", m_reg[2], 64'h55);
    peek("opq_reg2", 4'h2, 64'h55);

    step(1, 4'h2, 4'h1, 4'h3, 0, 0, 0, 64'd7, 64'd0, 0);
    peek("cmov_nc", 4'h3, 64'd0);
    step(1, 4'h2, 4'h1, 4'h3, 0, 0, 1, 64'd7, 64'd0, 0);
    peek("cmov_c", 4'h3, 64'd7);

    step(1, 4'hB, 4'h4, 4'hF, 0, 0, 0, 64'd520, 64'hBEEF, 0);
    peek("popq_rsp", 4'h4, 64'hBEEF);

    step(1, 4'h0, 4'hF, 4'hF, 0, 0, 0, 64'd0, 64'd0, 0);
    chk("halt_stat", {62'd0, stat}, 64'd1);
    step(1, 4'h3, 4'hF, 4'h5, 0, 0, 0, 64'd9, 64'd0, 0);
    peek("halt_blk", 4'h5, 64'd0);
    step(1, 4'h3, 4'hF, 4'h5, 0, 0, 0, 64'd9, 64'd0, 1);
    chk("rst_hlt_stat", {62'd0, stat}, 64'd0);
    peek("rst_hlt_rsp", 4'h4, 64'd512);

    step(1, 4'h3, 4'hF, 4'h6, 1, 1, 0, 64'd11, 64'd0, 0);
    chk("ins_stat", {62'd0, stat}, 64'd3);
    peek("ins_blk", 4'h6, 64'd0);
    step(0, 4'h3, 4'hF, 4'h6, 0, 0, 0, 64'd0, 64'd0, 1);
    step(0, 4'h3, 4'hF, 4'h6, 0, 0, 0, 64'd13, 64'd0, 0);
    peek("inval_reg6", 4'h6, 64'd0);
    chk("inval_stat", {62'd0, stat}, 64'd0);

    for (int n = 0; n < 600; n++) begin
      r = ($urandom_range(0, 59) == 0) ||
          (m_stat != 2'd0 && $urandom_range(0, 3) == 0);
      ic = ($urandom_range(0, 19) == 0) ? 4'h0
         : 4'($urandom_range(1, 15));
      step($urandom_range(0, 7) != 0, ic,
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           $urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0,
           1'($urandom_range(0, 1)),
           {$urandom, $urandom}, {$urandom, $urandom}, r);
    end
    idle();
    for (int i = 0; i < 16; i++)
      peek("final_reg", 4'(i), m_rd(4'(i)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
